ex_stage: RTL and testbench

- Execute stage. Consumes the decoded operation held in the ID/EX pipeline register and produces the GPR write-back result and the HI/LO write request for the EX/MEM register.
- Contains single-cycle logic, shift and arithmetic units, plus an iterative 32-step restoring divider.
- While a division is in progress, the divider holds the pipeline by raising stallreq_o toward the stall controller.

---
 rtl/ex_stage_if.sv | 31 +++
 rtl/ex_stage.sv | 207 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ex_stage_if -- ID/EX operand bundle into the execute stage and its
// EX/MEM-bound results.
//   Inputs to EX : aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i
//   Outputs of EX: wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
// master: the upstream pipeline register (drives operands).
// slave : ex_stage.
interface ex_stage_if;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        annul_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );
    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage -- execute stage: single-cycle logic/shift/arith units plus an
// iterative 32-step restoring divider that stalls the pipeline while busy.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus (slave): ex_stage_if operand inputs and result/HI-LO/stall outputs
// Optional feature macro: EX_MULT_EN (single-cycle MULT/MULTU into HI/LO);
// when undefined MULT/MULTU behave as NOP.
module ex_stage #(
    parameter int DIV_STEPS = 32
) (
    input logic     clk,
    input logic     rst,
    ex_stage_if.slave bus
);
    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_SLT  = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU = 8'b0010_1011;
    localparam logic [7:0] OP_ADDU = 8'b0010_0001;
    localparam logic [7:0] OP_SUBU = 8'b0010_0011;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;
`ifdef EX_MULT_EN
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
`endif
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DZERO, S_DONE} div_state_t;

    div_state_t  r_state, w_state_nxt;
    logic [31:0] r_q;       // dividend shifts out of the top, quotient in at the bottom
    logic [31:0] r_rem;
    logic [31:0] r_div;
    logic [31:0] r_raw1;    // unmodified dividend, reported as remainder on /0
    logic        r_qneg, r_rneg;
    logic [5:0]  r_cnt;

    logic        w_is_div, w_signed, w_stall;
    logic [31:0] w_abs1, w_abs2, w_quot, w_remd, w_res;
    logic [32:0] w_shift, w_sub;
    logic        w_valid;

    assign w_is_div = (bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_DIVU);
    assign w_signed = (bus.aluop_i == OP_DIV);
    assign w_abs1   = (w_signed && bus.reg1_i[31]) ? -bus.reg1_i : bus.reg1_i;
    assign w_abs2   = (w_signed && bus.reg2_i[31]) ? -bus.reg2_i : bus.reg2_i;

    // One restoring step: bring in the next dividend bit, trial-subtract.
    assign w_shift  = {r_rem, r_q[31]};
    assign w_sub    = w_shift - {1'b0, r_div};

    assign w_quot   = r_qneg ? -r_q : r_q;
    assign w_remd   = r_rneg ? -r_rem : r_rem;

    // Divider next-state and stall request
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        if (bus.annul_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_is_div) begin
                    w_stall     = 1'b1;
                    w_state_nxt = (bus.reg2_i == 32'd0) ? S_DZERO : S_RUN;
                end
                S_RUN: begin
                    w_stall = 1'b1;
                    if (r_cnt == 6'(DIV_STEPS - 1)) w_state_nxt = S_DONE;
                end
                S_DZERO: begin
                    w_stall     = 1'b1;
                    w_state_nxt = S_DONE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_raw1  <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!bus.annul_i) begin
                case (r_state)
                    S_IDLE: if (w_is_div) begin
                        r_q    <= w_abs1;
                        r_div  <= w_abs2;
                        r_raw1 <= bus.reg1_i;
                        r_rem  <= '0;
                        r_cnt  <= '0;
                        r_qneg <= w_signed & (bus.reg1_i[31] ^ bus.reg2_i[31]);
                        r_rneg <= w_signed & bus.reg1_i[31];
                    end
                    S_RUN: begin
                        if (!w_sub[32]) begin
                            r_rem <= w_sub[31:0];
                            r_q   <= {r_q[30:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[31:0];
                            r_q   <= {r_q[30:0], 1'b0};
                        end
                        r_cnt <= r_cnt + 6'd1;
                    end
                    S_DZERO: begin
                        r_q    <= '1;
                        r_rem  <= r_raw1;
                        r_qneg <= 1'b0;
                        r_rneg <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Single-cycle units; a result is valid only when aluop belongs to alusel's group.
    always_comb begin
        w_res   = '0;
        w_valid = 1'b0;
        case (bus.alusel_i)
            SEL_LOGIC: begin
                w_valid = 1'b1;
                case (bus.aluop_i)
                    OP_AND:  w_res = bus.reg1_i & bus.reg2_i;
                    OP_OR:   w_res = bus.reg1_i | bus.reg2_i;
                    OP_XOR:  w_res = bus.reg1_i ^ bus.reg2_i;
                    OP_NOR:  w_res = ~(bus.reg1_i | bus.reg2_i);
                    default: w_valid = 1'b0;
                endcase
            end
            SEL_SHIFT: begin
                w_valid = 1'b1;
                case (bus.aluop_i)
                    OP_SLL:  w_res = bus.reg2_i << bus.reg1_i[4:0];
                    OP_SRL:  w_res = bus.reg2_i >> bus.reg1_i[4:0];
                    OP_SRA:  w_res = $unsigned($signed(bus.reg2_i) >>> bus.reg1_i[4:0]);
                    default: w_valid = 1'b0;
                endcase
            end
            SEL_ARITH: begin
                w_valid = 1'b1;
                case (bus.aluop_i)
                    OP_ADDU: w_res = bus.reg1_i + bus.reg2_i;
                    OP_SUBU: w_res = bus.reg1_i - bus.reg2_i;
                    OP_SLT:  w_res = {31'd0, $signed(bus.reg1_i) < $signed(bus.reg2_i)};
                    OP_SLTU: w_res = {31'd0, bus.reg1_i < bus.reg2_i};
                    default: w_valid = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

`ifdef EX_MULT_EN
    logic [63:0] w_prod;
    assign w_prod = (bus.aluop_i == OP_MULT)
                  ? $unsigned($signed({{32{bus.reg1_i[31]}}, bus.reg1_i}) *
                              $signed({{32{bus.reg2_i[31]}}, bus.reg2_i}))
                  : {32'd0, bus.reg1_i} * {32'd0, bus.reg2_i};
`endif

    // Outputs are forced to zero for as long as reset is asserted.
    always_comb begin
        bus.wd_o       = '0;
        bus.wreg_o     = 1'b0;
        bus.wdata_o    = '0;
        bus.whilo_o    = 1'b0;
        bus.hi_o       = '0;
        bus.lo_o       = '0;
        bus.stallreq_o = 1'b0;
        if (!rst) begin
            bus.wd_o       = bus.wd_i;
            bus.wreg_o     = bus.wreg_i & w_valid;
            bus.wdata_o    = w_res;
            bus.stallreq_o = w_stall;
            if (r_state == S_DONE && !bus.annul_i) begin
                bus.whilo_o = 1'b1;
                bus.hi_o    = w_remd;
                bus.lo_o    = w_quot;
            end
`ifdef EX_MULT_EN
            else if (bus.aluop_i == OP_MULT || bus.aluop_i == OP_MULTU) begin
                bus.whilo_o = 1'b1;
                bus.hi_o    = w_prod[63:32];
                bus.lo_o    = w_prod[31:0];
            end
`endif
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_AND   = 8'b0010_0100;
    localparam logic [7:0] OP_OR    = 8'b0010_0101;
    localparam logic [7:0] OP_XOR   = 8'b0010_0110;
    localparam logic [7:0] OP_NOR   = 8'b0010_0111;
    localparam logic [7:0] OP_SLL   = 8'b0111_1100;
    localparam logic [7:0] OP_SRL   = 8'b0000_0010;
    localparam logic [7:0] OP_SRA   = 8'b0000_0011;
    localparam logic [7:0] OP_SLT   = 8'b0010_1010;
    localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
    localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
    localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_MUL   = 3'b101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ex_stage_if bus();
    ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

    // Reference: result and the alusel group that owns each single-cycle op.
    function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b, output logic [2:0] grp);
        logic [31:0] r;
        r = 32'd0;
        grp = SEL_NOP;
        case (op)
            OP_AND:  begin r = a & b;    grp = SEL_LOGIC; end
            OP_OR:   begin r = a | b;    grp = SEL_LOGIC; end
            OP_XOR:  begin r = a ^ b;    grp = SEL_LOGIC; end
            OP_NOR:  begin r = ~(a | b); grp = SEL_LOGIC; end
            OP_SLL:  begin r = b << (a % 32); grp = SEL_SHIFT; end
            OP_SRL:  begin r = b >> (a % 32); grp = SEL_SHIFT; end
            OP_SRA:  begin r = 32'($signed(64'($signed(b))) >>> (a % 32)); grp = SEL_SHIFT; end
            OP_ADDU: begin r = 32'(64'(a) + 64'(b)); grp = SEL_ARITH; end
            OP_SUBU: begin r = 32'(64'(a) - 64'(b)); grp = SEL_ARITH; end
            OP_SLT:  begin r = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0; grp = SEL_ARITH; end
            OP_SLTU: begin r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0; grp = SEL_ARITH; end
            default: ;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd, input logic wreg);
        bus.aluop_i  = op;
        bus.alusel_i = sel;
        bus.reg1_i   = a;
        bus.reg2_i   = b;
        bus.wd_i     = wd;
        bus.wreg_i   = wreg;
        bus.annul_i  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(OP_OR, SEL_LOGIC, 32'h1234, 32'h5678, 5'd9, 1'b1);
        #1;
        n_chk++;
        if ({bus.wd_o, bus.wreg_o, bus.wdata_o, bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: wdata=%h wd=%0d wreg=%b stall=%b, required all zero",
                     bus.wdata_o, bus.wd_o, bus.wreg_o, bus.stallreq_o);
        end
        step();
        rst = 1'b0;
        drive(OP_NOP, SEL_NOP, 0, 0, 0, 0);
        step();
    endtask

    // Directed entries first, then random ops with mostly-matching alusel.
    task automatic test_alu();
        logic [7:0]  d_op[4]  = '{OP_OR, OP_SRA, OP_SLT, OP_SLTU};
        logic [2:0]  d_sel[4] = '{SEL_LOGIC, SEL_SHIFT, SEL_ARITH, SEL_ARITH};
        logic [31:0] d_a[4]   = '{32'h0000FF00, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] d_b[4]   = '{32'h00F0F0F0, 32'h80000000, 32'd1, 32'd1};
        logic [31:0] d_exp[4] = '{32'h00F0FFF0, 32'hF8000000, 32'd1, 32'd0};
        logic [7:0]  ops[12]  = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                                  OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU, OP_NOP};
        for (int i = 0; i < 44; i++) begin
            logic [7:0] op; logic [2:0] sel, grp; logic [31:0] a, b, exp; logic wr, ok; logic [4:0] wd;
            if (i < 4) begin
                op = d_op[i]; sel = d_sel[i]; a = d_a[i]; b = d_b[i]; wd = 5'd5; wr = 1'b1;
            end else begin
                op = ops[$urandom_range(0, 11)];
                a = $urandom; b = $urandom; wd = 5'($urandom); wr = 1'($urandom);
                if (i % 8 == 0) a = a & 32'h1F;
                void'(ref_alu(op, a, b, grp));
                sel = ($urandom_range(0, 3) == 0) ? 3'($urandom) : grp;
            end
            exp = ref_alu(op, a, b, grp);
            ok  = (grp != SEL_NOP) && (sel == grp);
            if (!ok) exp = 32'd0;
            if (i < 4 && exp !== d_exp[i]) begin
                $display("note: reference disagrees with table entry %0d", i);
            end
            drive(op, sel, a, b, wd, wr);
            @(negedge clk);
            n_chk++;
            if (bus.wdata_o !== exp || bus.wreg_o !== (wr & ok) || bus.wd_o !== wd) begin
                n_fail++;
                $display("FAIL alu[%0d] op=%h sel=%b a=%h b=%h: got wdata=%h wreg=%b wd=%0d, required %h %b %0d",
                         i, op, sel, a, b, bus.wdata_o, bus.wreg_o, bus.wd_o, exp, wr & ok, wd);
            end
            n_chk++;
            if ({bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o} !== '0) begin
                n_fail++;
                $display("FAIL alu_side[%0d]: whilo=%b hi=%h lo=%h stall=%b, required all zero",
                         i, bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o);
            end
            step();
        end
    endtask

    // Starts a divide at posedge+1, follows it to the result cycle, returns at posedge+1.
    task automatic do_div(input string name, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int stalls, exp_stalls; logic bad; logic [31:0] elo, ehi;
        longint sa, sb;
        if (b == 0) begin
            exp_stalls = 2; elo = 32'hFFFFFFFF; ehi = a;
        end else if (op == OP_DIVU) begin
            exp_stalls = 33; elo = a / b; ehi = a % b;
        end else begin
            exp_stalls = 33;
            sa = longint'($signed(a)); sb = longint'($signed(b));
            elo = 32'(sa / sb); ehi = 32'(sa % sb);
        end
        drive(op, SEL_NOP, a, b, 5'd7, 1'b1);
        stalls = 0; bad = 1'b0;
        forever begin
            @(negedge clk);
            if (!bus.stallreq_o) break;
            if (bus.whilo_o !== 1'b0 || bus.wreg_o !== 1'b0) bad = 1'b1;
            stalls++;
            if (stalls > 40) break;
            step();
        end
        n_chk++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy: whilo/wreg seen high while stalled, required low", name);
        end
        n_chk++;
        if (stalls != exp_stalls) begin
            n_fail++;
            $display("FAIL %s_stall_cycles: got %0d, required %0d", name, stalls, exp_stalls);
        end
        n_chk++;
        if (bus.whilo_o !== 1'b1 || bus.lo_o !== elo || bus.hi_o !== ehi || bus.wreg_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_result %h/%h: got whilo=%b lo=%h hi=%h wreg=%b, required 1 %h %h 0",
                     name, a, b, bus.whilo_o, bus.lo_o, bus.hi_o, bus.wreg_o, elo, ehi);
        end
        step();
    endtask

    task automatic test_div();
        do_div("div_neg7_2", OP_DIV, 32'hFFFFFFF9, 32'd2);
        do_div("divu_100_0", OP_DIVU, 32'd100, 32'd0);
        do_div("div_minint", OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        do_div("div_by0_neg", OP_DIV, 32'hFFFFFF00, 32'd0);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            a = $urandom; b = (i % 2) ? $urandom : ($urandom & 32'hFF);
            do_div("div_rand", (i < 3) ? OP_DIV : OP_DIVU, a, b);
        end
        drive(OP_NOP, SEL_NOP, 0, 0, 0, 0);
        @(negedge clk);
        n_chk++;
        if (bus.whilo_o !== 1'b0 || bus.stallreq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL div_after_idle: whilo=%b stall=%b, required 0 0", bus.whilo_o, bus.stallreq_o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        do_div("b2b_first", OP_DIVU, 32'd50000, 32'd123);
        do_div("b2b_second", OP_DIV, 32'hFFFF0000, 32'd9);
        do_div("b2b_third", OP_DIVU, 32'd5, 32'd0);
        drive(OP_NOP, SEL_NOP, 0, 0, 0, 0);
        step();
    endtask

    task automatic test_annul();
        logic seen;
        drive(OP_DIVU, SEL_NOP, 32'd1000, 32'd7, 5'd2, 1'b0);
        repeat (11) step();
        n_chk++;
        if (bus.stallreq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL annul_pre_stall: got %b, required 1", bus.stallreq_o);
        end
        bus.annul_i = 1'b1;
        #1;
        n_chk++;
        if (bus.stallreq_o !== 1'b0 || bus.whilo_o !== 1'b0) begin
            n_fail++;
            $display("FAIL annul_cycle: stall=%b whilo=%b, required 0 0", bus.stallreq_o, bus.whilo_o);
        end
        step();
        drive(OP_NOP, SEL_NOP, 0, 0, 0, 0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.stallreq_o !== 1'b0 || bus.whilo_o !== 1'b0) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL annul_no_result: stall/whilo went high after annul, required idle");
        end
        step();
        do_div("annul_fresh", OP_DIVU, 32'd1000, 32'd7);
        drive(OP_NOP, SEL_NOP, 0, 0, 0, 0);
        step();
    endtask

    task automatic test_reset_mid_div();
        drive(OP_DIVU, SEL_NOP, 32'd12345, 32'd17, 5'd4, 1'b1);
        repeat (16) step();
        n_chk++;
        if (bus.stallreq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre_stall: got %b, required 1", bus.stallreq_o);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({bus.wd_o, bus.wreg_o, bus.wdata_o, bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: wd=%0d stall=%b whilo=%b, required all zero",
                     bus.wd_o, bus.stallreq_o, bus.whilo_o);
        end
        drive(OP_NOP, SEL_NOP, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        #1;
        n_chk++;
        if (bus.stallreq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle: stall=%b, required 0", bus.stallreq_o);
        end
        step();
        do_div("rstmid_9_3", OP_DIVU, 32'd9, 32'd3);
        drive(OP_NOP, SEL_NOP, 0, 0, 0, 0);
        step();
    endtask

    task automatic test_mult();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] op; logic [31:0] a, b, ehi, elo; logic ew;
            logic [63:0] p;
            op = (i % 2) ? OP_MULTU : OP_MULT;
            a = $urandom; b = $urandom;
            if (op == OP_MULT) p = 64'(longint'($signed(a)) * longint'($signed(b)));
            else               p = 64'(a) * 64'(b);
`ifdef EX_MULT_EN
            ew = 1'b1; ehi = p[63:32]; elo = p[31:0];
`else
            ew = 1'b0; ehi = 32'd0; elo = 32'd0;
`endif
            drive(op, SEL_MUL, a, b, 5'd8, 1'b1);
            @(negedge clk);
            n_chk++;
            if (bus.whilo_o !== ew || bus.hi_o !== ehi || bus.lo_o !== elo ||
                bus.wreg_o !== 1'b0 || bus.stallreq_o !== 1'b0) begin
                n_fail++;
                $display("FAIL mult[%0d] %h*%h: got whilo=%b hi=%h lo=%h wreg=%b stall=%b, required %b %h %h 0 0",
                         i, a, b, bus.whilo_o, bus.hi_o, bus.lo_o, bus.wreg_o, bus.stallreq_o, ew, ehi, elo);
            end
            step();
        end
        drive(OP_NOP, SEL_NOP, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_div();
        test_back_to_back();
        test_annul();
        test_reset_mid_div();
        test_mult();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
